// File: rtl/axis_lrelu_frame_tx.sv
`timescale 1ns/1ps
// axis_lrelu_frame_tx
// Frames the conv-core output for the LReLU engine: per layer, the config block
// (21 beats for 3x3, 9 for 1x1) followed by the conv data beats up to tlast.
// A two-entry skid buffer with registered outputs feeds the master port.
module axis_lrelu_frame_tx #(
    parameter int WORD_WIDTH_IN    = 32,
    parameter int UNITS            = 8,
    parameter int GROUPS           = 2,
    parameter int COPIES           = 2,
    parameter int MEMBERS          = 2,
    parameter int TUSER_WIDTH      = 8,
    parameter int CONFIG_BEATS_3X3 = 21,
    parameter int CONFIG_BEATS_1X1 = 9,
    parameter int INDEX_IS_3X3     = 0,
    localparam int DW = MEMBERS * COPIES * GROUPS * UNITS * WORD_WIDTH_IN,
    localparam int KW = MEMBERS * COPIES * GROUPS
) (
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   s_config_tvalid,
    output logic                   s_config_tready,
    input  logic [DW-1:0]          s_config_tdata,
    input  logic [TUSER_WIDTH-1:0] s_config_tuser,
    input  logic                   s_config_tlast,
    input  logic                   s_data_tvalid,
    output logic                   s_data_tready,
    input  logic [DW-1:0]          s_data_tdata,
    input  logic [KW-1:0]          s_data_tkeep,
    input  logic                   s_data_tlast,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic [DW-1:0]          m_axis_tdata,
    output logic [TUSER_WIDTH-1:0] m_axis_tuser,
    output logic [KW-1:0]          m_axis_tkeep,
    output logic                   m_axis_tlast,
    output logic                   cfg_err
);

    localparam int CFG_MAX = (CONFIG_BEATS_3X3 > CONFIG_BEATS_1X1) ? CONFIG_BEATS_3X3 : CONFIG_BEATS_1X1;
    localparam int CW      = (CFG_MAX > 1) ? $clog2(CFG_MAX) : 1;
    localparam logic [CW-1:0] CNT_3X3 = CW'(CONFIG_BEATS_3X3 - 2);
    localparam logic [CW-1:0] CNT_1X1 = CW'(CONFIG_BEATS_1X1 - 2);

    typedef enum logic [1:0] {
        CFG_FIRST = 2'd0,
        CFG_REST  = 2'd1,
        DATA      = 2'd2
    } state_t;

    state_t                 state;
    logic [CW-1:0]          count;
    logic [TUSER_WIDTH-1:0] layer_user;

    logic                   sel_cfg;
    logic                   in_vld;
    logic                   in_fire;
    logic [DW-1:0]          in_data;
    logic [TUSER_WIDTH-1:0] in_user;
    logic [KW-1:0]          in_keep;
    logic                   in_last;
    logic                   out_load;

    logic                   skid_vld_p1;
    logic [DW-1:0]          skid_data_p1;
    logic [TUSER_WIDTH-1:0] skid_user_p1;
    logic [KW-1:0]          skid_keep_p1;
    logic                   skid_last_p1;

    // Input mux: only the source owned by the current phase sees tready
    always_comb begin
        sel_cfg         = (state != DATA);
        s_config_tready = sel_cfg && !skid_vld_p1;
        s_data_tready   = !sel_cfg && !skid_vld_p1;
        in_vld          = sel_cfg ? s_config_tvalid : s_data_tvalid;
        in_fire         = in_vld && !skid_vld_p1;
        in_data         = sel_cfg ? s_config_tdata : s_data_tdata;
        in_user         = (state == CFG_FIRST) ? s_config_tuser : layer_user;
        in_keep         = sel_cfg ? {KW{1'b1}} : s_data_tkeep;
        in_last         = sel_cfg ? 1'b0 : s_data_tlast;
        out_load        = !m_axis_tvalid || m_axis_tready;
    end

    // Phase sequencing by beat count; config tlast is only cross-checked into cfg_err
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state      <= CFG_FIRST;
            count      <= '0;
            layer_user <= '0;
            cfg_err    <= 1'b0;
        end else if (in_fire) begin
            case (state)
                CFG_FIRST: begin
                    layer_user <= s_config_tuser;
                    count      <= s_config_tuser[INDEX_IS_3X3] ? CNT_3X3 : CNT_1X1;
                    state      <= CFG_REST;
                    if (s_config_tlast) cfg_err <= 1'b1;
                end
                CFG_REST: begin
                    if (s_config_tlast != (count == '0)) cfg_err <= 1'b1;
                    if (count == '0) state <= DATA;
                    else             count <= count - CW'(1);
                end
                DATA: begin
                    if (s_data_tlast) state <= CFG_FIRST;
                end
                default: state <= CFG_FIRST;
            endcase
        end
    end

    // Skid buffer: output register refills from the skid entry first, else from the input
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            skid_vld_p1   <= 1'b0;
            skid_data_p1  <= '0;
            skid_user_p1  <= '0;
            skid_keep_p1  <= '0;
            skid_last_p1  <= 1'b0;
        end else if (out_load) begin
            if (skid_vld_p1) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= skid_data_p1;
                m_axis_tuser  <= skid_user_p1;
                m_axis_tkeep  <= skid_keep_p1;
                m_axis_tlast  <= skid_last_p1;
                skid_vld_p1   <= 1'b0;
            end else begin
                m_axis_tvalid <= in_fire;
                if (in_fire) begin
                    m_axis_tdata <= in_data;
                    m_axis_tuser <= in_user;
                    m_axis_tkeep <= in_keep;
                    m_axis_tlast <= in_last;
                end
            end
        end else if (in_fire) begin
            skid_vld_p1  <= 1'b1;
            skid_data_p1 <= in_data;
            skid_user_p1 <= in_user;
            skid_keep_p1 <= in_keep;
            skid_last_p1 <= in_last;
        end
    end

endmodule

// File: tb/tb_axis_lrelu_frame_tx.sv
`timescale 1ns/1ps
// Bench for axis_lrelu_frame_tx: directed layers, scoreboard of framed beats.
module tb_axis_lrelu_frame_tx;

    localparam int DW = 2 * 2 * 2 * 8 * 32;
    localparam int KW = 2 * 2 * 2;
    localparam int TW = 8;

    typedef struct {
        logic [DW-1:0] data;
        logic [TW-1:0] user;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk;
    logic          areset;
    logic          s_config_tvalid;
    logic          s_config_tready;
    logic [DW-1:0] s_config_tdata;
    logic [TW-1:0] s_config_tuser;
    logic          s_config_tlast;
    logic          s_data_tvalid;
    logic          s_data_tready;
    logic [DW-1:0] s_data_tdata;
    logic [KW-1:0] s_data_tkeep;
    logic          s_data_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [TW-1:0] m_axis_tuser;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic          cfg_err;

    beat_t sb[$];
    beat_t e;
    beat_t prev;
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    npop, first_cyc, last_cyc;
    int    cfg_hs;
    bit    sticky_err = 0;
    bit    rnd_mode   = 0;
    bit    stall_prev = 0;

    axis_lrelu_frame_tx dut (
        .aclk            (aclk),
        .areset          (areset),
        .s_config_tvalid (s_config_tvalid),
        .s_config_tready (s_config_tready),
        .s_config_tdata  (s_config_tdata),
        .s_config_tuser  (s_config_tuser),
        .s_config_tlast  (s_config_tlast),
        .s_data_tvalid   (s_data_tvalid),
        .s_data_tready   (s_data_tready),
        .s_data_tdata    (s_data_tdata),
        .s_data_tkeep    (s_data_tkeep),
        .s_data_tlast    (s_data_tlast),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tuser    (m_axis_tuser),
        .m_axis_tkeep    (m_axis_tkeep),
        .m_axis_tlast    (m_axis_tlast),
        .cfg_err         (cfg_err)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(input logic [3:0] kind, input int lid, input int i);
        logic [31:0] w;
        w = {kind, 4'h0, lid[7:0], i[15:0]};
        return {(DW/32){w}};
    endfunction

    function automatic logic [KW-1:0] keep_pat(input int lid, input int j);
        return KW'(lid * 29 + j * 53 + 1);
    endfunction

    // expected framing of one layer
    task automatic push_layer(input int lid, input int ncfg, input logic [TW-1:0] tu, input int nd);
        beat_t b;
        for (int i = 0; i < ncfg; i++) begin
            b.data = pat(4'hC, lid, i); b.user = tu; b.keep = '1; b.last = 1'b0;
            sb.push_back(b);
        end
        for (int j = 0; j < nd; j++) begin
            b.data = pat(4'hD, lid, j); b.user = tu; b.keep = keep_pat(lid, j); b.last = (j == nd - 1);
            sb.push_back(b);
        end
    endtask

    task automatic send_cfg(input int lid, input int n, input logic [TW-1:0] tu, input int bad, input bit lat);
        bit got;
        int t;
        for (int i = 0; i < n; i++) begin
            s_config_tvalid = 1'b1;
            s_config_tdata  = pat(4'hC, lid, i);
            s_config_tuser  = (i == 0) ? tu : ~tu;
            s_config_tlast  = (bad < 0) ? (i == n - 1) : (i == bad);
            got = 1'b0; t = 0;
            while (!got && t < 1000) begin
                @(negedge aclk);
                got = s_config_tready;
                t++;
            end
            chk("cfg_handshake", got, 1);
            if (!got) break;
            if (lat && i == 0) chk("lat_before", m_axis_tvalid, 0);
            @(posedge aclk); #1;
            cfg_hs++;
            if (lat && i == 0) chk("lat_after", m_axis_tvalid, 1);
            sticky_err = sticky_err | (bad >= 0 && i >= bad);
            chk("cfg_err", cfg_err, sticky_err);
        end
        s_config_tvalid = 1'b0;
        s_config_tlast  = 1'b0;
    endtask

    task automatic send_data(input int lid, input int nsend, input int ntot, input int expcfg);
        bit got;
        int t;
        for (int j = 0; j < nsend; j++) begin
            s_data_tvalid = 1'b1;
            s_data_tdata  = pat(4'hD, lid, j);
            s_data_tkeep  = keep_pat(lid, j);
            s_data_tlast  = (j == ntot - 1);
            got = 1'b0; t = 0;
            while (!got && t < 1000) begin
                @(negedge aclk);
                got = s_data_tready;
                t++;
            end
            chk("data_handshake", got, 1);
            if (!got) break;
            if (j == 0 && expcfg >= 0) chk("cfg_beats_before_data", cfg_hs, expcfg);
            @(posedge aclk); #1;
        end
        s_data_tvalid = 1'b0;
        s_data_tlast  = 1'b0;
    endtask

    task automatic run_layer(input int lid, input int ncfg, input logic [TW-1:0] tu, input int nd,
                             input int bad, input bit lat, input int expcfg);
        fork
            send_cfg(lid, ncfg, tu, bad, lat);
            send_data(lid, nd, nd, expcfg);
        join
    endtask

    task automatic clear_stats();
        npop = 0; first_cyc = 0; last_cyc = 0; cfg_hs = 0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(negedge aclk);
            t++;
        end
        chk("drain_left", sb.size(), 0);
        @(posedge aclk); #1;
    endtask

    // output backpressure source
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge aclk); #1;
            m_axis_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // scoreboard monitor and stability checks, sampled on the falling edge
    always @(negedge aclk) begin
        if (!areset) begin
            chk("tready_exclusive", s_config_tready & s_data_tready, 0);
            if (stall_prev) begin
                n_tests++;
                assert (m_axis_tvalid === 1'b1 && m_axis_tdata === prev.data && m_axis_tuser === prev.user &&
                        m_axis_tkeep === prev.keep && m_axis_tlast === prev.last) else begin
                    n_fail++;
                    $error("FAIL hold_stable: observed v=%b d=%h u=%h k=%h l=%b expected v=1 d=%h u=%h k=%h l=%b",
                           m_axis_tvalid, m_axis_tdata[31:0], m_axis_tuser, m_axis_tkeep, m_axis_tlast,
                           prev.data[31:0], prev.user, prev.keep, prev.last);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                n_tests++;
                assert (sb.size() != 0) else begin
                    n_fail++;
                    $error("FAIL extra_beat: observed data=%h expected no beat", m_axis_tdata[31:0]);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    n_tests++;
                    assert (m_axis_tdata === e.data && m_axis_tuser === e.user &&
                            m_axis_tkeep === e.keep && m_axis_tlast === e.last) else begin
                        n_fail++;
                        $error("FAIL beat_%0d: observed d=%h u=%h k=%h l=%b expected d=%h u=%h k=%h l=%b",
                               npop, m_axis_tdata[31:0], m_axis_tuser, m_axis_tkeep, m_axis_tlast,
                               e.data[31:0], e.user, e.keep, e.last);
                    end
                    if (npop == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    npop++;
                end
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            prev.data  = m_axis_tdata;
            prev.user  = m_axis_tuser;
            prev.keep  = m_axis_tkeep;
            prev.last  = m_axis_tlast;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        areset          = 1'b1;
        s_config_tvalid = 1'b0;
        s_config_tdata  = '0;
        s_config_tuser  = '0;
        s_config_tlast  = 1'b0;
        s_data_tvalid   = 1'b0;
        s_data_tdata    = '0;
        s_data_tkeep    = '0;
        s_data_tlast    = 1'b0;
        clear_stats();

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata[63:0], 0);
        chk("rst_tuser", m_axis_tuser, 0);
        chk("rst_tkeep", m_axis_tkeep, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_cfg_err", cfg_err, 0);
        areset = 1'b0;
        @(negedge aclk);
        chk("rst_cfg_ready", s_config_tready, 1);
        chk("rst_data_ready", s_data_tready, 0);
        @(posedge aclk); #1;

        // 1x1 layer, full throughput, first-beat latency
        clear_stats();
        push_layer(1, 9, 8'h00, 4);
        run_layer(1, 9, 8'h00, 4, -1, 1'b1, 9);
        drain();
        chk("l1_beats", npop, 13);
        chk("l1_span", last_cyc - first_cyc, 12);

        // 3x3 layer
        clear_stats();
        push_layer(2, 21, 8'h03, 6);
        run_layer(2, 21, 8'h03, 6, -1, 1'b0, 21);
        drain();
        chk("l2_beats", npop, 27);
        chk("l2_span", last_cyc - first_cyc, 26);

        // back-to-back layers, all valids held, no idle cycle
        clear_stats();
        push_layer(3, 9, 8'h04, 3);
        push_layer(4, 21, 8'h01, 5);
        fork
            begin send_cfg(3, 9, 8'h04, -1, 1'b0); send_cfg(4, 21, 8'h01, -1, 1'b0); end
            begin send_data(3, 3, 3, 9); send_data(4, 5, 5, 30); end
        join
        drain();
        chk("b2b_beats", npop, 38);
        chk("b2b_span", last_cyc - first_cyc, 37);

        // same two-layer shape under random backpressure
        clear_stats();
        rnd_mode = 1'b1;
        push_layer(5, 9, 8'h10, 4);
        push_layer(6, 21, 8'h05, 4);
        fork
            begin send_cfg(5, 9, 8'h10, -1, 1'b0); send_cfg(6, 21, 8'h05, -1, 1'b0); end
            begin send_data(5, 4, 4, 9); send_data(6, 4, 4, 30); end
        join
        drain();
        rnd_mode = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        chk("rnd_beats", npop, 38);

        // early config tlast on beat 5 of a 1x1 block
        clear_stats();
        push_layer(7, 9, 8'h02, 2);
        run_layer(7, 9, 8'h02, 2, 4, 1'b0, 9);
        drain();
        chk("err_beats", npop, 11);
        chk("err_sticky", cfg_err, 1);

        // reset during data beat 3 of 6
        clear_stats();
        push_layer(8, 9, 8'h00, 6);
        send_cfg(8, 9, 8'h00, -1, 1'b0);
        send_data(8, 2, 6, 9);
        s_data_tvalid = 1'b1;
        s_data_tdata  = pat(4'hD, 8, 2);
        s_data_tkeep  = keep_pat(8, 2);
        s_data_tlast  = 1'b0;
        @(negedge aclk);
        #1;
        areset = 1'b1;
        #1;
        chk("midrst_tvalid", m_axis_tvalid, 0);
        chk("midrst_cfg_err", cfg_err, 0);
        s_data_tvalid = 1'b0;
        sb.delete();
        sticky_err = 1'b0;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        chk("post_rst_cfg_ready", s_config_tready, 1);
        chk("post_rst_data_ready", s_data_tready, 0);
        chk("post_rst_tvalid", m_axis_tvalid, 0);
        @(posedge aclk); #1;
        clear_stats();
        push_layer(9, 9, 8'h00, 3);
        run_layer(9, 9, 8'h00, 3, -1, 1'b0, 9);
        drain();
        chk("post_rst_beats", npop, 12);
        chk("post_rst_span", last_cyc - first_cyc, 11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
